// File: rtl/ebr_pingpong_ctrl.sv
// Ping-pong controller for one dual-port EBR split into two banks.
// The producer fills one bank while the consumer drains the other through a 2-entry output buffer.
module ebr_pingpong_ctrl #(
  parameter int BANK_AWIDTH = 6,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic [BANK_AWIDTH:0]  ebr_waddr,
  output logic                  ebr_write_en,
  output logic [DATA_WIDTH-1:0] ebr_din,
  output logic [BANK_AWIDTH:0]  ebr_raddr,
  input  logic [DATA_WIDTH-1:0] ebr_dout
);

  localparam logic [BANK_AWIDTH-1:0] IDX_MAX = '1;

  logic                   wbank;
  logic                   rbank;
  logic [BANK_AWIDTH-1:0] widx;
  logic [BANK_AWIDTH-1:0] ridx;
  logic [1:0]             bank_full;
  logic [1:0]             bank_full_next;
  logic                   inflight;
  logic                   inflight_last;
  logic [DATA_WIDTH-1:0]  head_data;
  logic [DATA_WIDTH-1:0]  tail_data;
  logic                   head_last;
  logic                   tail_last;
  logic [1:0]             count;
  logic                   wr_fire;
  logic                   pop;
  logic                   push;
  logic                   issue;
  logic                   wrap_w;
  logic                   wrap_r;
  logic [2:0]             fill_after_pop;

  assign wr_ready     = !bank_full[wbank];
  assign wr_fire      = wr_valid && wr_ready;
  assign ebr_write_en = wr_fire;
  assign ebr_waddr    = {wbank, widx};
  assign ebr_din      = wr_data;
  assign ebr_raddr    = {rbank, ridx};

  assign rd_valid = (count != 2'd0);
  assign rd_data  = head_data;
  assign rd_last  = head_last;

  assign pop  = rd_valid && rd_ready;
  assign push = inflight;

  // Only issue a read when the word it returns is guaranteed a buffer slot.
  assign fill_after_pop = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue          = bank_full[rbank] && (fill_after_pop < 3'd2);

  assign wrap_w = wr_fire && (widx == IDX_MAX);
  assign wrap_r = issue && (ridx == IDX_MAX);

  always_comb begin
    bank_full_next = bank_full;
    if (wrap_w) bank_full_next[wbank] = 1'b1;
    if (wrap_r) bank_full_next[rbank] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wbank     <= 1'b0;
      widx      <= '0;
      rbank     <= 1'b0;
      ridx      <= '0;
      bank_full <= 2'b00;
    end else begin
      bank_full <= bank_full_next;
      if (wr_fire) begin
        widx <= widx + 1'b1;
        if (wrap_w) wbank <= !wbank;
      end
      if (issue) begin
        ridx <= ridx + 1'b1;
        if (wrap_r) rbank <= !rbank;
      end
    end
  end

  // The last tag travels with the read so it lines up with ebr_dout a cycle later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (ridx == IDX_MAX);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_data <= '0;
      tail_data <= '0;
      head_last <= 1'b0;
      tail_last <= 1'b0;
      count     <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_data <= ebr_dout;
            head_last <= inflight_last;
          end else begin
            tail_data <= ebr_dout;
            tail_last <= inflight_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          head_last <= tail_last;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_data <= ebr_dout;
            head_last <= inflight_last;
          end else begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= ebr_dout;
            tail_last <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

  always @(posedge clock) begin
    if (reset_n) assert (count <= 2'd2 && !(push && !pop && count == 2'd2));
  end

endmodule
